// File: rtl/shtp_spi_framer.sv
// SHTP packet framer for the BNO085, sitting above a byte-level SPI master.
// Define SHTP_SEQ_CHECK_EN to add seq_err and per-channel rx sequence tracking.
module shtp_spi_framer #(
  parameter int CS_SETUP_CYC = 8,
  parameter int CS_HOLD_CYC  = 16,
  parameter int MAX_PAYLOAD  = 256,
  parameter int LEN_W        = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             int_n,
  output logic             cs_n,
  output logic             spi_start,
  output logic             spi_tx_valid,
  output logic [7:0]       spi_tx_data,
  input  logic             spi_tx_ready,
  input  logic             spi_rx_valid,
  input  logic [7:0]       spi_rx_data,
  input  logic             spi_busy,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_channel,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_byte_valid,
  input  logic [7:0]       cmd_byte,
  output logic             cmd_byte_ready,
  output logic             hdr_valid,
  output logic [7:0]       hdr_channel,
  output logic [7:0]       hdr_seq,
  output logic [14:0]      hdr_len,
  output logic             hdr_cont,
  output logic             rx_valid,
  output logic [7:0]       rx_data,
  output logic             rx_last,
  input  logic             rx_ready,
`ifdef SHTP_SEQ_CHECK_EN
  output logic             seq_err,
`endif
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, HDR, PAYLOAD, CS_HOLD
  } state_t;

  state_t state, state_nx;

  logic [15:0]      cnt;
  logic [LEN_W-1:0] idx;
  logic [LEN_W-1:0] tx_len;
  logic [LEN_W-1:0] rx_pay;
  logic [LEN_W-1:0] n_tot;
  logic [LEN_W-1:0] rx_pay_c;
  logic [LEN_W-1:0] n_c;
  logic [2:0]       tx_ch;
  logic [7:0]       seq_q [8];
  logic [7:0]       ch_q;
  logic [15:0]      len_q;
  logic             outst;
  logic             done;
  logic             issue;
  logic             need_cmd;
  logic             hdr_tx;
  logic             hdr_last;
  logic             pay_last;
  logic [14:0]      tot;
  logic [14:0]      lf;
  logic [14:0]      lm4;
  logic [7:0]       tx_byte;

  // Payload length the sensor announced, clamped; 0x7FFF means not ready.
  always_comb begin
    lf       = len_q[14:0];
    lm4      = lf - 15'd4;
    rx_pay_c = '0;
    if (lf >= 15'd4 && lf != 15'h7fff) begin
      if (lm4 > 15'(MAX_PAYLOAD))
        rx_pay_c = LEN_W'(MAX_PAYLOAD);
      else
        rx_pay_c = LEN_W'(lm4);
    end
    n_c = (rx_pay_c > tx_len) ? rx_pay_c : tx_len;
  end

  assign need_cmd = (state == PAYLOAD) && (idx < tx_len);
  assign hdr_tx   = (state == HDR) && (tx_len != '0);
  assign done     = outst && spi_rx_valid;
  assign hdr_last = (state == HDR) && done && (idx == LEN_W'(3));
  assign pay_last = (state == PAYLOAD) && done
                  && (idx == n_tot - 1'b1);

  assign issue = (state == HDR || state == PAYLOAD)
               && spi_tx_ready && !spi_busy
               && !outst && !rx_valid
               && (!need_cmd || cmd_byte_valid);

  assign tot = 15'(tx_len) + 15'd4;

  always_comb begin
    tx_byte = 8'h00;
    unique case (1'b1)
      hdr_tx: begin
        unique case (idx[1:0])
          2'd0:    tx_byte = tot[7:0];
          2'd1:    tx_byte = {1'b0, tot[14:8]};
          2'd2:    tx_byte = {5'b0, tx_ch};
          default: tx_byte = seq_q[tx_ch];
        endcase
      end
      need_cmd: tx_byte = cmd_byte;
      default:  tx_byte = 8'h00;
    endcase
  end

  assign spi_start      = issue;
  assign spi_tx_valid   = issue;
  assign spi_tx_data    = issue ? tx_byte : 8'h00;
  assign cmd_byte_ready = issue && need_cmd;
  assign cmd_ready      = (state == IDLE) && cmd_valid;
  assign cs_n           = (state == IDLE) || (state == CS_HOLD);
  assign busy           = (state != IDLE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (cmd_valid || !int_n) state_nx = CS_SETUP;
      CS_SETUP:
        if (cnt == 16'(CS_SETUP_CYC - 1)) state_nx = HDR;
      HDR:
        if (hdr_last)
          state_nx = (n_c == '0) ? CS_HOLD : PAYLOAD;
      PAYLOAD:
        if (pay_last) state_nx = CS_HOLD;
      CS_HOLD:
        if (cnt == 16'(CS_HOLD_CYC - 1)) state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      outst <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= (state_nx != state) ? '0 : cnt + 16'd1;
      if (state_nx != state)
        idx <= '0;
      else if (done)
        idx <= idx + 1'b1;
      if (issue)
        outst <= 1'b1;
      else if (spi_rx_valid)
        outst <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_len      <= '0;
      tx_ch       <= '0;
      rx_pay      <= '0;
      n_tot       <= '0;
      ch_q        <= '0;
      len_q       <= '0;
      hdr_valid   <= 1'b0;
      hdr_channel <= '0;
      hdr_seq     <= '0;
      hdr_len     <= '0;
      hdr_cont    <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      rx_last     <= 1'b0;
      for (int i = 0; i < 8; i++)
        seq_q[i] <= '0;
    end else begin
      hdr_valid <= 1'b0;
      if (state == IDLE) begin
        tx_len <= cmd_valid ? cmd_len : '0;
        if (cmd_valid)
          tx_ch <= cmd_channel;
      end
      if (state == HDR && done) begin
        unique case (idx[1:0])
          2'd0:    len_q[7:0]  <= spi_rx_data;
          2'd1:    len_q[15:8] <= spi_rx_data;
          2'd2:    ch_q        <= spi_rx_data;
          default: ;
        endcase
      end
      if (hdr_last) begin
        hdr_valid   <= 1'b1;
        hdr_len     <= len_q[14:0];
        hdr_cont    <= len_q[15];
        hdr_channel <= ch_q;
        hdr_seq     <= spi_rx_data;
        rx_pay      <= rx_pay_c;
        n_tot       <= n_c;
        if (tx_len != '0)
          seq_q[tx_ch] <= seq_q[tx_ch] + 8'd1;
      end
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
        rx_last  <= 1'b0;
      end
      // No byte is issued while rx_valid is set, so set/clear never collide.
      if (state == PAYLOAD && done && idx < rx_pay) begin
        rx_valid <= 1'b1;
        rx_data  <= spi_rx_data;
        rx_last  <= (idx == rx_pay - 1'b1);
      end
    end
  end

`ifdef SHTP_SEQ_CHECK_EN
  logic [7:0] exp_q [8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_err <= 1'b0;
      for (int i = 0; i < 8; i++)
        exp_q[i] <= '0;
    end else begin
      seq_err <= 1'b0;
      if (hdr_last) begin
        seq_err <= (rx_pay_c != '0)
                && (spi_rx_data != exp_q[ch_q[2:0]]);
        exp_q[ch_q[2:0]] <= spi_rx_data + 8'd1;
      end
    end
  end
`endif

endmodule
